// File: rtl/vram_slot_arbiter.sv
// Arbitrates one single-port synchronous VRAM between a video fetcher and the CPU.
// Active display alternates video/CPU slots on hpos[0]; blanking is round-robin.
module vram_slot_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        hpos,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              vid_enable,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rddata,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wrdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rddata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_wren,
    output logic [DATA_W-1:0] vram_wrdata,
    input  logic [DATA_W-1:0] vram_rddata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    owner_e            own1_q, own1_d, own2_q, own2_d;
    logic              vid_out_q, vid_out_d, cpu_out_q, cpu_out_d;
    logic              last_cpu_q, last_cpu_d;
    logic              vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] vid_rddata_q, vid_rddata_d, cpu_rddata_q, cpu_rddata_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic              vram_wren_q, vram_wren_d;
    logic [DATA_W-1:0] vram_wrdata_q, vram_wrdata_d;

    logic vid_elig, cpu_elig, blank, grant_vid, grant_cpu;

    // Only the slot parity of hpos matters.
    logic hpos_unused;
    assign hpos_unused = ^hpos[9:1];

    always_comb begin
        vid_elig  = vid_req & vid_enable & ~vid_out_q;
        cpu_elig  = cpu_req & ~cpu_out_q;
        blank     = hblank | vblank;
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (vid_elig && cpu_elig) begin
            grant_vid = blank ? last_cpu_q : ~hpos[0];
            grant_cpu = ~grant_vid;
        end else begin
            grant_vid = vid_elig;
            grant_cpu = cpu_elig;
        end

        own1_d = grant_vid ? OWN_VID : (grant_cpu ? OWN_CPU : OWN_NONE);
        own2_d = own1_q;

        // Acks come solely from the owner pipeline; rddata is captured alongside.
        vid_ack_d    = (own2_q == OWN_VID);
        cpu_ack_d    = (own2_q == OWN_CPU);
        vid_rddata_d = vid_ack_d ? vram_rddata : vid_rddata_q;
        cpu_rddata_d = cpu_ack_d ? vram_rddata : cpu_rddata_q;

        vram_addr_d   = grant_vid ? vid_addr : (grant_cpu ? cpu_addr : vram_addr_q);
        vram_wren_d   = grant_cpu & cpu_wr;
        vram_wrdata_d = (grant_cpu & cpu_wr) ? cpu_wrdata : vram_wrdata_q;

        // Outstanding flag drops at the edge that ends the ack cycle.
        vid_out_d  = grant_vid | (vid_out_q & ~vid_ack_q);
        cpu_out_d  = grant_cpu | (cpu_out_q & ~cpu_ack_q);
        last_cpu_d = grant_cpu ? 1'b1 : (grant_vid ? 1'b0 : last_cpu_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            own1_q        <= OWN_NONE;
            own2_q        <= OWN_NONE;
            vid_out_q     <= 1'b0;
            cpu_out_q     <= 1'b0;
            last_cpu_q    <= 1'b1;
            vid_ack_q     <= 1'b0;
            cpu_ack_q     <= 1'b0;
            vid_rddata_q  <= '0;
            cpu_rddata_q  <= '0;
            vram_addr_q   <= '0;
            vram_wren_q   <= 1'b0;
            vram_wrdata_q <= '0;
        end else begin
            own1_q        <= own1_d;
            own2_q        <= own2_d;
            vid_out_q     <= vid_out_d;
            cpu_out_q     <= cpu_out_d;
            last_cpu_q    <= last_cpu_d;
            vid_ack_q     <= vid_ack_d;
            cpu_ack_q     <= cpu_ack_d;
            vid_rddata_q  <= vid_rddata_d;
            cpu_rddata_q  <= cpu_rddata_d;
            vram_addr_q   <= vram_addr_d;
            vram_wren_q   <= vram_wren_d;
            vram_wrdata_q <= vram_wrdata_d;
        end
    end

    assign vid_ack     = vid_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign vid_rddata  = vid_rddata_q;
    assign cpu_rddata  = cpu_rddata_q;
    assign vram_addr   = vram_addr_q;
    assign vram_wren   = vram_wren_q;
    assign vram_wrdata = vram_wrdata_q;

endmodule
